pix_box_downsampler: RTL and testbench

//  Box-average downsampler that sits between the VGA pixel stream and the 32x32 image RAMs.
//  It takes the 224x224 grey capture window from the VGA controller and averages each 8x8 block.
//  The result is a 28x28 image, zero-padded to 32x32 and written to image_mem / echo_mem.

---
 rtl/pix_box_downsampler.sv | 151 +++++++++++++++
 tb/tb_pix_box_downsampler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pix_box_downsampler.sv
`timescale 1ns/1ps
// pix_box_downsampler: averages each 8x8 block of the 224x224 grey window into a zero-padded 32x32 image.
// Build option: define INVERT_EN to write 255-average for interior blocks (white digit on black).
module pix_box_downsampler #(
  parameter int SRC_DIM = 224,
  parameter int BLK     = 8,
  parameter int PAD     = 2,
  parameter int PIX_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_color_in,
  input  logic [7:0]       pix_haddr,
  input  logic [7:0]       pix_vaddr,
  output logic             wr_en,
  output logic [9:0]       wr_addr,
  output logic [PIX_W-1:0] wr_data,
  output logic             busy,
  output logic             done
);

  // state    | meaning
  // IDLE     | waiting for start
  // CLEAR    | zero-filling RAM addresses 0..1023
  // WAIT_SOF | discarding pixels until a valid (0,0)
  // ACCUM    | summing pixels, writing one average per completed block
  // FIN      | last block written; done pulse follows
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_SOF, ACCUM, FIN} state_t;

  localparam int LB      = $clog2(BLK);
  localparam int OUT_DIM = SRC_DIM / BLK;
  localparam int COL_W   = $clog2(OUT_DIM);
  localparam int ACC_W   = PIX_W + 2 * LB;
  localparam logic [7:0]       LIM   = 8'(SRC_DIM);
  localparam logic [7:0]       LAST  = 8'(SRC_DIM - 1);
  localparam logic [4:0]       PAD_O = 5'(PAD);
  localparam logic [ACC_W-1:0] HALF  = ACC_W'(1 << (2 * LB - 1));

  state_t state, state_d;

  logic [ACC_W-1:0] acc [OUT_DIM];
  logic [9:0]       clr_addr;

  logic             in_range, is_sof, blk_end, is_last;
  logic [COL_W-1:0] col, row;
  logic [4:0]       blk_row, blk_col;
  logic [ACC_W-1:0] acc_sum, rnd;
  logic [PIX_W-1:0] avg, blk_data;

  logic             wr_en_d, busy_d, done_d;
  logic [9:0]       wr_addr_d;
  logic [PIX_W-1:0] wr_data_d;

  assign in_range = pix_valid && (pix_haddr < LIM) && (pix_vaddr < LIM);
  assign is_sof   = in_range && (pix_haddr == 8'd0) && (pix_vaddr == 8'd0);
  assign blk_end  = in_range && (&pix_haddr[LB-1:0]) && (&pix_vaddr[LB-1:0]);
  assign is_last  = in_range && (pix_haddr == LAST) && (pix_vaddr == LAST);

  assign col     = pix_haddr[LB +: COL_W];
  assign row     = pix_vaddr[LB +: COL_W];
  assign blk_col = col + PAD_O;
  assign blk_row = row + PAD_O;

  // Worst-case sum plus the rounding half still fits ACC_W bits, so no carry out.
  assign acc_sum = acc[col] + ACC_W'(pix_color_in);
  assign rnd     = acc_sum + HALF;
  assign avg     = PIX_W'(rnd >> (2 * LB));

`ifdef INVERT_EN
  assign blk_data = {PIX_W{1'b1}} - avg;
`else
  assign blk_data = avg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    case (state)
      IDLE: begin
        // A start coinciding with the done pulse belongs to the finished run.
        if (start && !done) state_d = CLEAR;
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_addr;
        wr_data_d = '0;
        if (clr_addr == 10'h3FF) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (is_sof) state_d = ACCUM;
      end
      ACCUM: begin
        if (blk_end) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {blk_row, blk_col};
          wr_data_d = blk_data;
          if (is_last) state_d = FIN;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + 10'd1;
    else                     clr_addr <= '0;
  end

  // A (0,0) pixel starts a fresh frame both from WAIT_SOF and as a mid-frame restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
    end else if (is_sof && (state == WAIT_SOF || state == ACCUM)) begin
      for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
      acc[0] <= ACC_W'(pix_color_in);
    end else if (state == ACCUM && in_range) begin
      if (blk_end) acc[col] <= '0;
      else         acc[col] <= acc_sum;
    end
  end

endmodule

// File: tb/tb_pix_box_downsampler.sv
`timescale 1ns/1ps
// Randomized bench for pix_box_downsampler against a block-sum reference model.
module tb_pix_box_downsampler;

  logic       clk = 1'b0;
  logic       rst, start, pix_valid;
  logic [7:0] pix_color_in, pix_haddr, pix_vaddr;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, done;

  pix_box_downsampler dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
    .pix_color_in(pix_color_in), .pix_haddr(pix_haddr), .pix_vaddr(pix_vaddr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int a; int d; int c;} wr_t;
  wr_t  act_q[$];
  wr_t  exp_q[$];
  int   done_q[$];
  int   n_chk = 0, n_pass = 0, cyc = 0, busy_viol = 0;
  logic [7:0] img [224][224];

  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (wr_en) begin
      w.a = int'(wr_addr);
      w.d = int'(wr_data);
      w.c = cyc;
      act_q.push_back(w);
    end
    if (done) done_q.push_back(cyc);
    if (wr_en && !busy) busy_viol++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  task automatic put(input logic vld, input int h, input int v, input int p);
    pix_valid    = vld;
    pix_haddr    = 8'(h);
    pix_vaddr    = 8'(v);
    pix_color_in = 8'(p);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 0, 0, 0);
  endtask

  task automatic put_junk();
    case ($urandom_range(2))
      0: put(1'b0, $urandom_range(255), $urandom_range(255), $urandom_range(255));
      1: put(1'b1, 224 + $urandom_range(31), $urandom_range(223), $urandom_range(255));
      default: put(1'b1, $urandom_range(223), 224 + $urandom_range(31), $urandom_range(255));
    endcase
  endtask

  task automatic feed(input int r0, input int r1, input bit junk, input bit starts);
    for (int r = r0; r < r1; r++)
      for (int c = 0; c < 224; c++) begin
        if (junk && $urandom_range(63) == 0) put_junk();
        start = starts && ($urandom_range(1023) == 0);
        put(1'b1, c, r, int'(img[r][c]));
        start = 1'b0;
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 224; r++)
      for (int c = 0; c < 224; c++) img[r][c] = 8'($urandom);
  endtask

  task automatic model_clear();
    for (int a = 0; a < 1024; a++) begin
      wr_t w;
      w.a = a; w.d = 0; w.c = 0;
      exp_q.push_back(w);
    end
  endtask

  task automatic model_frame(input int rows);
    for (int br = 0; br < 28 && br * 8 + 7 < rows; br++)
      for (int bc = 0; bc < 28; bc++) begin
        int sum;
        int avg;
        wr_t w;
        sum = 0;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) sum += int'(img[br*8+r][bc*8+c]);
        avg = (sum + 32) / 64;
`ifdef INVERT_EN
        avg = 255 - avg;
`endif
        w.a = (br + 2) * 32 + bc + 2; w.d = avg; w.c = 0;
        exp_q.push_back(w);
      end
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && act_q.size() < n; i++) idle(1);
    check(tag, int'(act_q.size() >= n), 1);
  endtask

  task automatic compare(input string run);
    check($sformatf("%s write count", run), act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      if (n_chk - n_pass > 40) break;
      check($sformatf("%s addr[%0d]", run, i), act_q[i].a, exp_q[i].a);
      check($sformatf("%s data[%0d]", run, i), act_q[i].d, exp_q[i].d);
    end
  endtask

  initial begin
    int t_last;
    int k;
    int n_before;
    bit seen;
    rst = 1'b1; start = 1'b0;
    pix_valid = 1'b0; pix_color_in = '0; pix_haddr = '0; pix_vaddr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset wr_en", int'(wr_en), 0);
    check("reset wr_addr", int'(wr_addr), 0);
    check("reset wr_data", int'(wr_data), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Run 1: partial frame A (rows 0..15), restart, full frame B.
    fill_random();
    model_clear();
    model_frame(16);
    start = 1'b1; idle(1); start = 1'b0;
    check("busy after start", int'(busy), 1);
    idle(20);
    start = 1'b1; idle(1); start = 1'b0;
    wait_writes(1024, 1200, "clear finished");
    start = 1'b1; idle(1); start = 1'b0;
    for (int i = 0; i < 20; i++) put(1'b1, 1 + $urandom_range(222), $urandom_range(223), $urandom_range(255));
    feed(0, 16, 1'b1, 1'b0);
    idle(3);

    fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        img[r][c]           = (r < 4) ? 8'd0 : 8'd255;
        img[216+r][216+c]   = 8'd255;
        img[r][216+c]       = 8'd0;
      end
    model_frame(224);
    feed(0, 224, 1'b1, 1'b1);
    t_last = cyc;
    pix_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen  = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    check("done seen", int'(seen), 1);
    idle(30);
    compare("run1");
    k = 1024 + 56;
    check("blk00 addr", (k < act_q.size()) ? act_q[k].a : -1, 66);
`ifdef INVERT_EN
    check("blk00 data", (k < act_q.size()) ? act_q[k].d : -1, 127);
`else
    check("blk00 data", (k < act_q.size()) ? act_q[k].d : -1, 128);
`endif
    check("last addr", (act_q.size() > 0) ? act_q[act_q.size()-1].a : -1, 957);
    check("last write cycle", (act_q.size() > 0) ? act_q[act_q.size()-1].c : -1, t_last + 1);
    check("done count", done_q.size(), 1);
    check("done cycle", (done_q.size() > 0) ? done_q[0] : -1, t_last + 2);
    check("start at done ignored busy", int'(busy), 0);
    check("busy during writes", busy_viol, 0);

    // Run 2: reset in the middle of accumulation.
    act_q.delete(); exp_q.delete(); done_q.delete();
    fill_random();
    model_clear();
    model_frame(10);
    start = 1'b1; idle(1); start = 1'b0;
    wait_writes(1024, 1200, "clear2 finished");
    feed(0, 10, 1'b0, 1'b0);
    for (int c = 0; c < 50; c++) put(1'b1, c, 10, int'(img[10][c]));
    rst = 1'b1;
    @(negedge clk);
    check("midreset wr_en", int'(wr_en), 0);
    check("midreset wr_addr", int'(wr_addr), 0);
    check("midreset wr_data", int'(wr_data), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_before = act_q.size();
    put(1'b1, 0, 0, 55);
    feed(10, 14, 1'b0, 1'b0);
    check("post reset no writes", act_q.size(), n_before);
    check("post reset busy", int'(busy), 0);
    check("post reset done", done_q.size(), 0);
    compare("run2");
    check("busy during writes 2", busy_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
